sync_fifo_core: RTL and testbench
=================================

Name: sync_fifo_core

Overview:
Single-clock synchronous FIFO that sits directly behind the top-level pin wrapper. It takes byte writes from the dedicated input pins and supplies read data that the wrapper drives onto the dedicated output pins. It provides full, empty and almost-full status, an occupancy count, and sticky overflow/underflow error flags for debug visibility on the bidirectional pins.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; must be a power of 2, minimum 2
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push request
wr_data  input  WIDTH  push data; sampled when a push is accepted
rd_en  input  1  pop request
rd_data  output  WIDTH  registered pop data
rd_valid  output  1  high for one cycle when rd_data carries newly popped data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; set when a push is rejected
underflow  output  1  sticky; set when a pop is rejected
clr_err  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Outputs go immediately to empty=1, full=0, almost_full=0. Storage array is not reset.
- Reset release takes effect at the next clock edge. Reset asserted mid-operation discards all contents, with no partial update.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- Address = ptr[$clog2(DEPTH)-1:0].
- full = (addresses equal and wrap bits differ). empty = (pointers equal).
- count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- full, empty, almost_full and count are combinational from registered pointers, with no combinational path from wr_en or rd_en.
- Push accepted = wr_en && (!full || pop_accepted).
  - On accept: mem[wr_addr] <= wr_data and wr_ptr increments.
- Pop accepted = rd_en && !empty.
  - On accept: rd_data <= mem[rd_addr] at that edge, rd_ptr increments, and rd_valid=1 for the next cycle.
  - Read latency is 1 cycle: data is visible the cycle after rd_en is sampled.
- rd_valid is 0 in any cycle following no accepted pop. rd_data holds its last value when no pop occurs.
- Simultaneous push and pop:
  - Not empty: both are accepted and count is unchanged.
  - Full: both are accepted, a write-through slot is freed, and full stays 1.
  - Empty: only the push is accepted, the pop is rejected, and underflow is set. There is no bypass of the storage array.
- Rejected push (wr_en && full && !pop_accepted): data is dropped, pointers are unchanged, overflow <= 1.
- Rejected pop (rd_en && empty): rd_data unchanged, rd_valid=0, underflow <= 1.
- overflow and underflow stay set until clr_err is sampled high. If a set event and clr_err occur in the same cycle, the set wins.
- Wrap-around: pointers roll over naturally at 2^($clog2(DEPTH)+1), and ordering is preserved across the wrap.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with 3 entries stored -> empty=1, count=0, rd_valid=0, rd_data=0 immediately without a clock edge; after release, a pop sets underflow=1.
- Fill and drain: push 0x01..0x08 (DEPTH=8) -> almost_full=1 after the 6th push, full=1 after the 8th; then 8 pops -> rd_data 0x01..0x08 in order, each rd_valid one cycle after its rd_en; empty=1 at the end.
- Overflow: push 0xAA into a full FIFO with rd_en=0 -> overflow=1, count=8, and 0xAA never appears on rd_data. Pulse clr_err -> overflow=0. Raise clr_err in the same cycle as a new rejected push -> overflow stays 1.
- Simultaneous events: on a full FIFO, push 0x55 and pop together -> rd_data=oldest entry, count=8, full=1, 0x55 read last. On an empty FIFO, push 0x33 and pop together -> underflow=1, count=1, and the next pop returns 0x33.
- Wrap-around: run 20 cycles of continuous push and pop with count held at 3, data incrementing from 0x10 -> output sequence 0x10,0x11,... with no gaps or duplicates and count=3 throughout.

Source files
------------

// File: rtl/sync_fifo_core_if.sv
// rtl/sync_fifo_core_if.sv - push/pop/status bundle between the pin wrapper and sync_fifo_core
interface sync_fifo_core_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - single-clock FIFO with registered read, status flags and sticky error flags
module sync_fifo_core #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_core_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [PW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    // Status depends only on registered pointers, never on the request inputs.
    always_comb begin
        w_wr_addr = r_wr_ptr[AW-1:0];
        w_rd_addr = r_rd_ptr[AW-1:0];
        w_count   = r_wr_ptr - r_rd_ptr;
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
        w_pop     = bus.rd_en && !w_empty;
        w_push    = bus.wr_en && (!w_full || w_pop);
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (w_count >= PW'(AF_LEVEL));
    assign bus.count       = w_count;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;

    // Storage is deliberately left out of reset; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[w_rd_addr];
                r_rd_ptr  <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            // A new error event in the same cycle as clr_err keeps the flag set.
            if (bus.wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb/tb_sync_fifo_core.sv - directed and randomized checks of sync_fifo_core against a queue model
module tb_sync_fifo_core;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_core_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    string      phase = "init";

    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;
    logic       m_ovf;
    logic       m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("count",       32'(bus.count),       32'(q.size()));
        check("empty",       32'(bus.empty),       32'(q.size() == 0));
        check("full",        32'(bus.full),        32'(q.size() == DEPTH));
        check("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF_LEVEL));
        check("rd_valid",    32'(bus.rd_valid),    32'(m_rd_valid));
        check("rd_data",     32'(bus.rd_data),     32'(m_rd_data));
        check("overflow",    32'(bus.overflow),    32'(m_ovf));
        check("underflow",   32'(bus.underflow),   32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        logic pop_ok;
        logic push_ok;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.clr_err = ce;
        pop_ok  = re && (q.size() != 0);
        push_ok = we && ((q.size() < DEPTH) || pop_ok);
        m_rd_valid = pop_ok;
        if (pop_ok) m_rd_data = q.pop_front();
        if (push_ok) q.push_back(wd);
        if (we && !push_ok) m_ovf = 1'b1;
        else if (ce)        m_ovf = 1'b0;
        if (re && !pop_ok)  m_udf = 1'b1;
        else if (ce)        m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #2;
        phase = "reset";
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        phase = "midreset";
        cycle(1, 8'hA1, 0, 0);
        cycle(1, 8'hA2, 0, 0);
        cycle(1, 8'hA3, 0, 0);
        cycle(1, 8'hA4, 1, 0);
        #2;
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);

        phase = "fill_drain";
        for (int i = 1; i <= DEPTH; i++) cycle(1, 8'(i), 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        phase = "overflow";
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        cycle(1, 8'hAA, 0, 0);
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'hBB, 0, 1);
        cycle(0, 8'h00, 0, 1);

        phase = "full_pushpop";
        cycle(1, 8'h55, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

        phase = "empty_pushpop";
        cycle(1, 8'h33, 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);

        phase = "wrap";
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 8'(8'h13 + i), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);

        phase = "random";
        for (int i = 0; i < 500; i++) begin
            cycle(logic'($urandom_range(0, 99) < 55),
                  8'($urandom),
                  logic'($urandom_range(0, 99) < 50),
                  logic'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
